// File: rtl/regfile_port_ctrl_pkg.sv
// Shared types and default sizes for the register-file port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_A = 2'd1,
      SERVE_B = 2'd2
   } state_t;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   localparam int NREG_DEF     = 16;
   localparam int AW_DEF       = 4;
   localparam int MAXBURST_DEF = 8;

endpackage

// File: rtl/regfile_port_ctrl_onehot_decoder.sv
// Address to one-hot strobe decoder; addresses beyond the file decode to all zero.
// Latency: combinational.
// Backpressure: none.
module onehot_decoder #(
   parameter int NREG = 16,
   parameter int AW   = 4
) (
   input  logic            En,
   input  logic [AW-1:0]   Addr,
   output logic [NREG-1:0] Onehot
);

   // Compare against every implemented index so out-of-range addresses match nothing
   always_comb begin
      Onehot = '0;
      for (int i = 0; i < NREG; i++) begin
         Onehot[i] = En && (Addr == AW'(i));
      end
   end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Arbitrates two requesters onto the register file and drives one-hot Ld/Oe0/Oe1 strobes.
// Latency: Req sampled at edge t gives Gnt and strobes during cycle t..t+1; one access per SERVE cycle.
// Backpressure: a waiting requester holds Req until Gnt; round-robin with locked bursts capped at MAXBURST.
module regfile_port_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int NREG     = NREG_DEF,
   parameter int AW       = AW_DEF,
   parameter int MAXBURST = MAXBURST_DEF
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            ReqA,
   input  logic            WeA,
   input  logic [AW-1:0]   WaA,
   input  logic [AW-1:0]   RaA0,
   input  logic [AW-1:0]   RaA1,
   input  logic            LockA,
   input  logic            ReqB,
   input  logic            WeB,
   input  logic [AW-1:0]   WaB,
   input  logic [AW-1:0]   RaB0,
   input  logic [AW-1:0]   RaB1,
   input  logic            LockB,
   output logic            GntA,
   output logic            GntB,
   output logic [NREG-1:0] Ld,
   output logic [NREG-1:0] Oe0,
   output logic [NREG-1:0] Oe1,
   output logic            WSel,
   output logic            Busy
);

   // Burst counter reaches BURST_LIM on the last locked grant allowed while the other side waits
   localparam logic [7:0] BURST_LIM = 8'(MAXBURST - 1);

   state_t          state;
   state_t          state_nxt;
   logic            last;
   logic [7:0]      burst;
   logic            lock_stay;
   logic            serve;
   logic            sel_b;
   logic            we_sel;
   logic [AW-1:0]   wa_sel;
   logic [AW-1:0]   ra0_sel;
   logic [AW-1:0]   ra1_sel;
   logic [NREG-1:0] ld_nxt;
   logic [NREG-1:0] oe0_nxt;
   logic [NREG-1:0] oe1_nxt;

   // Pick who is served next: locked burst first, then hand over to a waiting peer, then repeat or idle
   always_comb begin
      state_nxt = IDLE;
      lock_stay = 1'b0;
      case (state)
         SERVE_A: begin
            if (LockA && ReqA && (!ReqB || burst < BURST_LIM)) begin
               state_nxt = SERVE_A;
               lock_stay = 1'b1;
            end else if (ReqB) begin
               state_nxt = SERVE_B;
            end else if (ReqA) begin
               state_nxt = SERVE_A;
            end
         end
         SERVE_B: begin
            if (LockB && ReqB && (!ReqA || burst < BURST_LIM)) begin
               state_nxt = SERVE_B;
               lock_stay = 1'b1;
            end else if (ReqA) begin
               state_nxt = SERVE_A;
            end else if (ReqB) begin
               state_nxt = SERVE_B;
            end
         end
         default: begin
            if (ReqA && ReqB) begin
               state_nxt = (last == REQ_B) ? SERVE_A : SERVE_B;
            end else if (ReqA) begin
               state_nxt = SERVE_A;
            end else if (ReqB) begin
               state_nxt = SERVE_B;
            end
         end
      endcase
   end

   // Route the incoming winner's access fields to the decoders so strobes register with the grant
   assign serve   = (state_nxt != IDLE);
   assign sel_b   = (state_nxt == SERVE_B);
   assign we_sel  = sel_b ? WeB  : WeA;
   assign wa_sel  = sel_b ? WaB  : WaA;
   assign ra0_sel = sel_b ? RaB0 : RaA0;
   assign ra1_sel = sel_b ? RaB1 : RaA1;

   onehot_decoder #(.NREG(NREG), .AW(AW)) u_dec_ld (
      .En     (serve && we_sel),
      .Addr   (wa_sel),
      .Onehot (ld_nxt)
   );

   onehot_decoder #(.NREG(NREG), .AW(AW)) u_dec_oe0 (
      .En     (serve),
      .Addr   (ra0_sel),
      .Onehot (oe0_nxt)
   );

   onehot_decoder #(.NREG(NREG), .AW(AW)) u_dec_oe1 (
      .En     (serve),
      .Addr   (ra1_sel),
      .Onehot (oe1_nxt)
   );

   // State, fairness pointer, burst count and all registered outputs; reset kills any access in flight
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         last  <= REQ_B;
         burst <= '0;
         GntA  <= 1'b0;
         GntB  <= 1'b0;
         Ld    <= '0;
         Oe0   <= '0;
         Oe1   <= '0;
         WSel  <= 1'b0;
         Busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (lock_stay) begin
            burst <= (burst != 8'hFF) ? burst + 8'd1 : burst;
         end else begin
            burst <= '0;
         end
         if (state != IDLE && state_nxt != state) begin
            last <= (state == SERVE_B) ? REQ_B : REQ_A;
         end
         GntA <= (state_nxt == SERVE_A);
         GntB <= sel_b;
         WSel <= sel_b;
         Busy <= serve;
         Ld   <= ld_nxt;
         Oe0  <= oe0_nxt;
         Oe1  <= oe1_nxt;
      end
   end

endmodule
